// File: rtl/robo_sequencer.sv
// Actuator sequencer for the rescue robot: arbitrates remote/nav commands,
// times one actuator per command, inserts a dead-time guard, honours estop.
module robo_sequencer #(
    parameter int unsigned T_AVANCA = 8,
    parameter int unsigned T_GIRO   = 4,
    parameter int unsigned T_COLETA = 12,
    parameter int unsigned T_GUARD  = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       nav_req,
    input  logic [1:0] nav_cmd,
    output logic       nav_ack,
    input  logic       rem_req,
    input  logic [1:0] rem_cmd,
    output logic       rem_ack,
    input  logic       estop,
    output logic       motor_fwd,
    output logic       motor_turn,
    output logic       garra,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int unsigned CNT_W = 8;

    // Zero-length durations are stretched to one cycle.
    localparam logic [CNT_W-1:0] L_AVANCA = (T_AVANCA == 0) ? CNT_W'(1) : CNT_W'(T_AVANCA);
    localparam logic [CNT_W-1:0] L_GIRO   = (T_GIRO   == 0) ? CNT_W'(1) : CNT_W'(T_GIRO);
    localparam logic [CNT_W-1:0] L_COLETA = (T_COLETA == 0) ? CNT_W'(1) : CNT_W'(T_COLETA);
    localparam logic [CNT_W-1:0] L_GUARD  = (T_GUARD  == 0) ? CNT_W'(1) : CNT_W'(T_GUARD);

    localparam logic [1:0] CMD_NONE   = 2'b00;
    localparam logic [1:0] CMD_AVANCA = 2'b01;
    localparam logic [1:0] CMD_GIRO   = 2'b10;
    localparam logic [1:0] CMD_COLETA = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_GUARD,
        S_STOP
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [1:0]         r_cmd;

    state_t             w_state_nx;
    logic [CNT_W-1:0]   w_cnt_nx;
    logic [1:0]         w_cmd_nx;
    logic               w_nav_ack_nx;
    logic               w_rem_ack_nx;
    logic               w_fwd_nx;
    logic               w_turn_nx;
    logic               w_garra_nx;
    logic               w_busy_nx;
    logic               w_done_nx;
    logic               w_err_nx;

    // Run length for a command; an invalid command occupies a single silent RUN cycle.
    function automatic logic [CNT_W-1:0] dur_of(input logic [1:0] cmd);
        case (cmd)
            CMD_AVANCA: dur_of = L_AVANCA;
            CMD_GIRO:   dur_of = L_GIRO;
            CMD_COLETA: dur_of = L_COLETA;
            default:    dur_of = CNT_W'(1);
        endcase
    endfunction

    // State, counter and registered outputs; reset clears everything asynchronously.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_cmd      <= CMD_NONE;
            nav_ack    <= 1'b0;
            rem_ack    <= 1'b0;
            motor_fwd  <= 1'b0;
            motor_turn <= 1'b0;
            garra      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_cnt      <= w_cnt_nx;
            r_cmd      <= w_cmd_nx;
            nav_ack    <= w_nav_ack_nx;
            rem_ack    <= w_rem_ack_nx;
            motor_fwd  <= w_fwd_nx;
            motor_turn <= w_turn_nx;
            garra      <= w_garra_nx;
            busy       <= w_busy_nx;
            done       <= w_done_nx;
            err        <= w_err_nx;
        end
    end

    // Next state, counter and output values; estop overrides every state.
    always_comb begin
        w_state_nx   = r_state;
        w_cnt_nx     = r_cnt;
        w_cmd_nx     = r_cmd;
        w_err_nx     = err;
        w_nav_ack_nx = 1'b0;
        w_rem_ack_nx = 1'b0;
        w_done_nx    = 1'b0;

        if (estop) begin
            w_state_nx = S_STOP;
            w_cnt_nx   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (rem_req || nav_req) begin
                        w_state_nx   = S_RUN;
                        w_cmd_nx     = rem_req ? rem_cmd : nav_cmd;
                        w_rem_ack_nx = rem_req;
                        w_nav_ack_nx = !rem_req;
                        w_cnt_nx     = dur_of(w_cmd_nx) - CNT_W'(1);
                        if (w_cmd_nx == CMD_NONE) begin
                            w_err_nx = 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (r_cnt == '0) begin
                        w_state_nx = S_GUARD;
                        w_cnt_nx   = L_GUARD - CNT_W'(1);
                    end else begin
                        w_cnt_nx = r_cnt - CNT_W'(1);
                    end
                end
                S_GUARD: begin
                    if (r_cnt == '0) begin
                        w_state_nx = S_IDLE;
                        w_done_nx  = (r_cmd != CMD_NONE);
                    end else begin
                        w_cnt_nx = r_cnt - CNT_W'(1);
                    end
                end
                S_STOP: begin
                    // Aborted command is dropped; a fresh request is needed.
                    w_state_nx = S_IDLE;
                    w_cnt_nx   = '0;
                end
                default: begin
                    w_state_nx = S_IDLE;
                    w_cnt_nx   = '0;
                end
            endcase
        end

        w_fwd_nx   = (w_state_nx == S_RUN) && (w_cmd_nx == CMD_AVANCA);
        w_turn_nx  = (w_state_nx == S_RUN) && (w_cmd_nx == CMD_GIRO);
        w_garra_nx = (w_state_nx == S_RUN) && (w_cmd_nx == CMD_COLETA);
        w_busy_nx  = (w_state_nx != S_IDLE);
    end

endmodule

// File: tb/tb_robo_sequencer.sv
// Bench for robo_sequencer: directed scenarios plus random traffic against a
// schedule-queue reference model.
module tb_robo_sequencer;

    localparam int unsigned T_AV = 8;
    localparam int unsigned T_GI = 4;
    localparam int unsigned T_CO = 12;
    localparam int unsigned T_GD = 2;

    logic       clock = 1'b0;
    logic       reset;
    logic       nav_req, rem_req, estop;
    logic [1:0] nav_cmd, rem_cmd;
    logic       nav_ack, rem_ack, motor_fwd, motor_turn, garra, busy, done, err;

    int n_cmp = 0;
    int n_bad = 0;

    robo_sequencer #(
        .T_AVANCA(T_AV), .T_GIRO(T_GI), .T_COLETA(T_CO), .T_GUARD(T_GD)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .nav_req   (nav_req),
        .nav_cmd   (nav_cmd),
        .nav_ack   (nav_ack),
        .rem_req   (rem_req),
        .rem_cmd   (rem_cmd),
        .rem_ack   (rem_ack),
        .estop     (estop),
        .motor_fwd (motor_fwd),
        .motor_turn(motor_turn),
        .garra     (garra),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clock = ~clock;

    // One cycle of expected outputs: {fwd, turn, garra, busy, done}.
    typedef logic [4:0] slot_t;
    slot_t q[$];
    logic  m_stop = 1'b0;
    logic  m_err  = 1'b0;
    logic  e_nav_ack, e_rem_ack;
    slot_t e_slot;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: at acceptance the whole command is planned as a list of
    // cycles (actuator cycles, guard cycles, closing done cycle); estop discards it.
    task automatic model_edge();
        logic [1:0]  cmd;
        int unsigned dur;
        e_nav_ack = 1'b0;
        e_rem_ack = 1'b0;
        if (estop) begin
            q.delete();
            m_stop = 1'b1;
            e_slot = 5'b00010;
        end else if (m_stop) begin
            m_stop = 1'b0;
            e_slot = 5'b00000;
        end else if (q.size() > 0) begin
            e_slot = q.pop_front();
        end else if (rem_req || nav_req) begin
            cmd = rem_req ? rem_cmd : nav_cmd;
            e_rem_ack = rem_req;
            e_nav_ack = !rem_req;
            dur = (cmd == 2'b01) ? T_AV : (cmd == 2'b10) ? T_GI : (cmd == 2'b11) ? T_CO : 1;
            for (int i = 0; i < int'(dur); i++)
                q.push_back({cmd == 2'b01, cmd == 2'b10, cmd == 2'b11, 1'b1, 1'b0});
            for (int i = 0; i < int'(T_GD); i++)
                q.push_back(5'b00010);
            q.push_back({4'b0000, cmd != 2'b00});
            if (cmd == 2'b00) m_err = 1'b1;
            e_slot = q.pop_front();
        end else begin
            e_slot = 5'b00000;
        end
    endtask

    function automatic logic [7:0] dut_vec();
        return {nav_ack, rem_ack, motor_fwd, motor_turn, garra, busy, done, err};
    endfunction

    // One clock: model the edge, compare mid-cycle, drop acknowledged requests.
    task automatic step(input string tag);
        @(posedge clock);
        model_edge();
        @(negedge clock);
        check_eq(tag, dut_vec(), {e_nav_ack, e_rem_ack, e_slot, m_err});
        check_eq("excl", 8'(32'(motor_fwd) + 32'(motor_turn) + 32'(garra) <= 1), 8'd1);
        if (e_nav_ack) nav_req = 1'b0;
        if (e_rem_ack) rem_req = 1'b0;
    endtask

    task automatic steps(input int n, input string tag);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    // Asynchronous reset in the low clock phase, checked before any edge.
    task automatic async_reset(input string tag);
        #2 reset = 1'b0;
        #1 check_eq(tag, dut_vec(), 8'h00);
        q.delete();
        m_stop = 1'b0;
        m_err  = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        reset   = 1'b0;
        nav_req = 1'b0; nav_cmd = 2'b00;
        rem_req = 1'b0; rem_cmd = 2'b00;
        estop   = 1'b0;
        #12 check_eq("reset", dut_vec(), 8'h00);
        @(negedge clock);
        reset = 1'b1;

        // Single advance.
        nav_req = 1'b1; nav_cmd = 2'b01;
        steps(T_AV + T_GD + 4, "advance");

        // Simultaneous remote turn and nav collect.
        rem_req = 1'b1; rem_cmd = 2'b10;
        nav_req = 1'b1; nav_cmd = 2'b11;
        steps(T_GI + T_GD + T_CO + T_GD + 5, "arbit");

        // Emergency stop during the third RUN cycle of an advance.
        nav_req = 1'b1; nav_cmd = 2'b01;
        steps(3, "pre_estop");
        estop = 1'b1;
        steps(5, "estop");
        estop = 1'b0;
        steps(6, "post_estop");

        // Invalid command then a valid turn.
        nav_req = 1'b1; nav_cmd = 2'b00;
        steps(T_GD + 3, "invalid");
        nav_req = 1'b1; nav_cmd = 2'b10;
        steps(T_GI + T_GD + 3, "after_inv");

        // Reset mid-collect, then a request accepted normally.
        nav_req = 1'b1; nav_cmd = 2'b11;
        steps(5, "collect");
        nav_req = 1'b1; nav_cmd = 2'b01;
        async_reset("async_rst");
        steps(T_AV + T_GD + 3, "post_rst");

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            if (!nav_req && ($urandom % 4 == 0)) begin
                nav_req = 1'b1; nav_cmd = 2'($urandom);
            end
            if (!rem_req && ($urandom % 9 == 0)) begin
                rem_req = 1'b1; rem_cmd = 2'($urandom);
            end
            if (estop) estop = ($urandom % 3 != 0);
            else       estop = ($urandom % 60 == 0);
            if ($urandom % 700 == 0) begin
                estop = 1'b0;
                async_reset("rnd_rst");
            end
            step("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/robo_sequencer.md
ROBO_SEQUENCER -- requirements
Module: robo_sequencer

Interface
REQ-001 SHALL have parameter T_AVANCA, default 8, motor_fwd duration in clock cycles for an advance command.
REQ-002 SHALL have parameter T_GIRO, default 4, motor_turn duration in clock cycles for a turn command.
REQ-003 SHALL have parameter T_COLETA, default 12, garra duration in clock cycles for a collect command.
REQ-004 SHALL have parameter T_GUARD, default 2, all-actuators-off dead time in cycles after every command.
REQ-005 SHALL have port clock  in  1  rising-edge clock for all state.
REQ-006 SHALL have port reset  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port nav_req  in  1  navigation FSM command request, held until nav_ack.
REQ-008 SHALL have port nav_cmd  in  2  navigation command: 01 advance, 10 turn, 11 collect, 00 invalid.
REQ-009 SHALL have port nav_ack  out  1  one-cycle pulse: nav command accepted.
REQ-010 SHALL have port rem_req  in  1  remote override request, held until rem_ack.
REQ-011 SHALL have port rem_cmd  in  2  remote command, same encoding as nav_cmd.
REQ-012 SHALL have port rem_ack  out  1  one-cycle pulse: remote command accepted.
REQ-013 SHALL have port estop  in  1  emergency stop, synchronous, active-high.
REQ-014 SHALL have port motor_fwd  out  1  drive forward motor.
REQ-015 SHALL have port motor_turn  out  1  drive turn motor.
REQ-016 SHALL have port garra  out  1  drive rubble-collection claw.
REQ-017 SHALL have port busy  out  1  high in every state except IDLE.
REQ-018 SHALL have port done  out  1  one-cycle pulse: command completed normally.
REQ-019 SHALL have port err  out  1  sticky flag: invalid command accepted.

Function
REQ-020 SHALL implement states IDLE, RUN, GUARD, STOP; all outputs registered.
REQ-021 IDLE: on edge N with a request pending and estop low, SHALL enter RUN, pulse the winner's ack in cycle N+1, and assert the selected actuator from cycle N+1.
REQ-022 Arbitration SHALL give rem_req fixed priority over nav_req; on simultaneous requests only rem_ack pulses and nav_req stays pending.
REQ-023 nav_ack and rem_ack SHALL never be high in the same cycle, and neither SHALL pulse outside the IDLE->RUN transition.
REQ-024 In RUN, exactly one actuator SHALL be high for exactly T cycles of the selected command; motor_fwd, motor_turn, and garra SHALL be mutually exclusive at all times.
REQ-025 The duration counter SHALL be 8 bits wide; a parameter value of 0 SHALL behave as 1.
REQ-026 RUN expiry SHALL enter GUARD with all actuators low for exactly T_GUARD cycles (0 treated as 1).
REQ-027 On GUARD exit, done SHALL pulse for one cycle and the state SHALL return to IDLE; the earliest next acceptance is on the following edge.
REQ-028 An accepted cmd 00 SHALL be acked, SHALL set err, SHALL drive no actuator, SHALL pulse no done, and SHALL pass through GUARD.
REQ-029 estop high at any edge, in any state, SHALL enter STOP; all actuators SHALL be low from the next cycle, busy SHALL be high, and no ack or done SHALL occur.
REQ-030 STOP SHALL persist while estop is high; the first edge with estop low SHALL return to IDLE; the aborted command SHALL NOT resume or retry.
REQ-031 In IDLE, estop SHALL take precedence over any pending request.
REQ-032 Requests arriving during RUN, GUARD, or STOP SHALL be held pending and not acked until IDLE.

Reset
REQ-033 reset low SHALL immediately force IDLE, clear the counter, and drive all outputs including err to 0, independent of clock, including mid-RUN.
REQ-034 After reset deasserts, the first acceptance SHALL occur no earlier than the first rising edge.

Verification
REQ-035 nav_req=1, nav_cmd=01: nav_ack pulses at N+1, motor_fwd high 8 cycles, 2 off cycles, done pulse, busy low after.
REQ-036 rem_req=1 (cmd 10) and nav_req=1 (cmd 11) same edge: rem_ack only, motor_turn 4 cycles; after done, nav_ack, garra 12 cycles.
REQ-037 estop=1 at the 3rd RUN cycle of an advance: motor_fwd low next cycle, STOP held for 5 cycles of estop, back to IDLE, no done, no re-ack of the same command.
REQ-038 nav_cmd=00 with nav_req=1: nav_ack pulses, err=1 and sticky, no actuator, no done; a subsequent valid command executes normally with err still 1.
REQ-039 reset low asynchronously mid-collect (garra=1): garra, busy, and err go to 0 without a clock edge; a request after release is accepted normally.
